// File: rtl/fm_pkg.sv
// Shared types and constants for the FM envelope generator.
// Holds the ADSR state encoding, level limits and the saturating level add.
package fm_pkg;

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } eg_state_t;

  localparam logic [8:0] EG_MAX   = 9'h1FF;
  localparam int         EG_CNT_W = 12;
  localparam int         TREM_MAX = 26;

  function automatic logic [8:0] eg_sat_add(input logic [8:0] lvl, input logic [3:0] inc);
    logic [9:0] sum;
    sum = {1'b0, lvl} + {6'd0, inc};
    return (sum > {1'b0, EG_MAX}) ? EG_MAX : sum[8:0];
  endfunction

endpackage

// File: rtl/fm_eg_rate.sv
// Rate decoder: turns a 4-bit rate and the frame counter into a step strobe and increment.
// Latency: combinational.
// Backpressure: none.
import fm_pkg::*;

module fm_eg_rate (
  input  logic [3:0]          rate,
  input  logic [EG_CNT_W-1:0] eg_cnt,
  output logic                step_en,
  output logic [3:0]          inc
);

  logic [EG_CNT_W-1:0] mask;

  always_comb begin
    mask    = {EG_CNT_W{1'b1}} >> rate;
    step_en = 1'b0;
    inc     = 4'd1;
    if (rate == 4'd0) begin
      step_en = 1'b0;
    end else if (rate <= 4'd12) begin
      // Higher rates look at fewer low counter bits, so they fire more often.
      step_en = (eg_cnt & mask) == '0;
    end else begin
      step_en = 1'b1;
      inc     = 4'd1 << (rate - 4'd12);
    end
  end

endmodule

// File: rtl/fm_eg.sv
// Time-multiplexed ADSR envelope generator; FM_EG_TREMOLO_EN adds the tremolo triangle.
// Latency: env/env_valid/env_idx are registered one cycle after the op_valid strobe.
// Backpressure: none; every strobe is accepted and the sequencer owns the schedule.
import fm_pkg::*;

module fm_eg #(
  parameter int NUM_OPS = 36
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       op_valid,
  input  logic [5:0] op_idx,
  input  logic       key_on,
  input  logic [3:0] ar,
  input  logic [3:0] dr,
  input  logic [3:0] sl,
  input  logic [3:0] rr,
  input  logic       egt,
  input  logic [5:0] tl,
  input  logic       am,
  output logic [8:0] env,
  output logic       env_valid,
  output logic [5:0] env_idx
);

  localparam logic [5:0] LAST_OP = 6'(NUM_OPS - 1);

  logic [8:0]          level_q [NUM_OPS];
  eg_state_t           state_q [NUM_OPS];
  logic [NUM_OPS-1:0]  prev_key_q;
  logic [EG_CNT_W-1:0] eg_cnt;

  logic       in_range;
  logic       wr_en;
  logic [5:0] rd_idx;

  assign in_range = op_idx <= LAST_OP;
  assign wr_en    = op_valid && in_range;
  assign rd_idx   = in_range ? op_idx : 6'd0;

  logic       ar_step, dr_step, rr_step;
  logic [3:0] ar_inc, dr_inc, rr_inc;

  fm_eg_rate u_ar (.rate(ar), .eg_cnt(eg_cnt), .step_en(ar_step), .inc(ar_inc));
  fm_eg_rate u_dr (.rate(dr), .eg_cnt(eg_cnt), .step_en(dr_step), .inc(dr_inc));
  fm_eg_rate u_rr (.rate(rr), .eg_cnt(eg_cnt), .step_en(rr_step), .inc(rr_inc));

  logic [8:0]  lvl, lvl_next;
  eg_state_t   st, st_next;
  logic        pk;
  logic [9:0]  att_sub;
  logic [10:0] env_sum;
  logic [8:0]  env_next;

`ifdef FM_EG_TREMOLO_EN
  logic [7:0] trem_cnt;
  logic [4:0] trem_val;
  logic       trem_up;
`else
  logic unused_am;
  assign unused_am = am;
`endif

  always_comb begin
    lvl      = level_q[rd_idx];
    st       = state_q[rd_idx];
    pk       = prev_key_q[rd_idx];
    lvl_next = lvl;
    st_next  = st;
    // Attack step shrinks with level: ((level>>3)+1)*inc, at most 512.
    att_sub  = ({4'd0, lvl[8:3]} + 10'd1) * {6'd0, ar_inc};

    if (key_on && !pk) begin
      st_next = ATTACK;
      if (ar == 4'hF) lvl_next = 9'd0;
    end else if (!key_on && pk) begin
      st_next = RELEASE;
    end else begin
      case (st)
        ATTACK: begin
          if (ar_step)
            lvl_next = (att_sub >= {1'b0, lvl}) ? 9'd0 : (lvl - att_sub[8:0]);
          if (lvl_next == 9'd0) st_next = DECAY;
        end
        DECAY: begin
          if (dr_step) lvl_next = eg_sat_add(lvl, dr_inc);
          if (lvl_next >= {sl, 4'b0000}) st_next = SUSTAIN;
        end
        SUSTAIN: begin
          if (!egt && rr_step) lvl_next = eg_sat_add(lvl, rr_inc);
        end
        default: begin
          if (rr_step) lvl_next = eg_sat_add(lvl, rr_inc);
        end
      endcase
    end

    env_sum = {2'b00, lvl_next} + {3'b000, tl, 2'b00};
`ifdef FM_EG_TREMOLO_EN
    if (am) env_sum = env_sum + {6'd0, trem_val};
`endif
    env_next = (env_sum > {2'b00, EG_MAX}) ? EG_MAX : env_sum[8:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        level_q[i] <= EG_MAX;
        state_q[i] <= RELEASE;
      end
      prev_key_q <= '0;
      eg_cnt     <= '0;
      env        <= EG_MAX;
      env_valid  <= 1'b0;
      env_idx    <= 6'd0;
    end else begin
      if (sample_tick) eg_cnt <= eg_cnt + 1'b1;
      if (wr_en) begin
        level_q[rd_idx]    <= lvl_next;
        state_q[rd_idx]    <= st_next;
        prev_key_q[rd_idx] <= key_on;
        env                <= env_next;
      end
      env_valid <= wr_en;
      env_idx   <= op_idx;
    end
  end

`ifdef FM_EG_TREMOLO_EN
  // Triangle 0..26..0: one unit per step, a step every 64 frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trem_cnt <= 8'd0;
      trem_val <= 5'd0;
      trem_up  <= 1'b1;
    end else if (sample_tick) begin
      trem_cnt <= trem_cnt + 8'd1;
      if (trem_cnt[5:0] == 6'd0) begin
        if (trem_up) begin
          trem_val <= trem_val + 5'd1;
          if (trem_val + 5'd1 == 5'(TREM_MAX)) trem_up <= 1'b0;
        end else begin
          trem_val <= trem_val - 5'd1;
          if (trem_val == 5'd1) trem_up <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fm_eg.sv
// Randomized and directed bench for fm_eg against a behavioural ADSR model.
module tb_fm_eg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       op_valid = 1'b0;
  logic [5:0] op_idx = '0;
  logic       key_on = 1'b0;
  logic [3:0] ar = '0, dr = '0, sl = '0, rr = '0;
  logic       egt = 1'b0;
  logic [5:0] tl = '0;
  logic       am = 1'b0;
  logic [8:0] env;
  logic       env_valid;
  logic [5:0] env_idx;

  fm_eg #(.NUM_OPS(36)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .op_valid(op_valid),
    .op_idx(op_idx), .key_on(key_on), .ar(ar), .dr(dr), .sl(sl), .rr(rr),
    .egt(egt), .tl(tl), .am(am), .env(env), .env_valid(env_valid), .env_idx(env_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model: 0=attack 1=decay 2=sustain 3=release.
  int m_lvl[64];
  int m_st[64];
  bit m_pk[64];
  int m_cnt = 0;
  int m_trem_cnt = 0;
  int m_trem_steps = 0;

  bit pend_vld = 0, exp_vld = 0, chk_en = 0;
  int pend_env = 0, exp_env = 0, pend_idx = 0, exp_idx = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic void rate_of(input int r, input int cnt, output bit st, output int inc);
    st = 0;
    inc = 1;
    if (r >= 13) begin
      st = 1;
      inc = 1 << (r - 12);
    end else if (r >= 1) begin
      st = (cnt % (1 << (12 - r))) == 0;
    end
  endfunction

  function automatic int trem_now();
    int k;
    k = m_trem_steps % 52;
    return (k <= 26) ? k : 52 - k;
  endfunction

  function automatic int model_step(input int i, input bit key, input int a, input int d,
                                    input int s, input int r, input bit e, input int t,
                                    input bit amv);
    int lvl, st, inc, sum;
    bit go;
    lvl = m_lvl[i];
    st = m_st[i];
    if (key && !m_pk[i]) begin
      st = 0;
      if (a == 15) lvl = 0;
    end else if (!key && m_pk[i]) begin
      st = 3;
    end else if (st == 0) begin
      rate_of(a, m_cnt, go, inc);
      if (go) lvl = lvl - ((lvl / 8) + 1) * inc;
      if (lvl < 0) lvl = 0;
      if (lvl == 0) st = 1;
    end else if (st == 1) begin
      rate_of(d, m_cnt, go, inc);
      if (go) lvl = (lvl + inc > 511) ? 511 : lvl + inc;
      if (lvl >= s * 16) st = 2;
    end else if (st == 3 || !e) begin
      rate_of(r, m_cnt, go, inc);
      if (go) lvl = (lvl + inc > 511) ? 511 : lvl + inc;
    end
    m_lvl[i] = lvl;
    m_st[i] = st;
    m_pk[i] = key;
    sum = lvl + 4 * t;
`ifdef FM_EG_TREMOLO_EN
    if (amv) sum = sum + trem_now();
`else
    if (amv) sum = sum + 0;
`endif
    return (sum > 511) ? 511 : sum;
  endfunction

  task automatic model_tick(input bit tick);
    if (tick) begin
      m_cnt = (m_cnt + 1) % 4096;
      if (m_trem_cnt % 64 == 0) m_trem_steps++;
      m_trem_cnt = (m_trem_cnt + 1) % 256;
    end
  endtask

  task automatic strobe(input int idx, input bit key, input int a, input int d, input int s,
                        input int r, input bit e, input int t, input bit amv, input bit tick);
    logic [31:0] v;
    op_valid = 1'b1;
    v = idx;  op_idx = v[5:0];
    key_on = key;
    v = a;  ar = v[3:0];
    v = d;  dr = v[3:0];
    v = s;  sl = v[3:0];
    v = r;  rr = v[3:0];
    egt = e;
    v = t;  tl = v[5:0];
    am = amv;
    sample_tick = tick;
    pend_idx = idx;
    pend_vld = idx < 36;
    if (pend_vld) pend_env = model_step(idx, key, a, d, s, r, e, t, amv);
    model_tick(tick);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    sample_tick = 1'b0;
    pend_vld = 0;
  endtask

  task automatic idle(input bit tick);
    sample_tick = tick;
    pend_vld = 0;
    model_tick(tick);
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_vld <= 0;
      exp_env <= 0;
      exp_idx <= 0;
    end else begin
      exp_vld <= pend_vld;
      exp_env <= pend_env;
      exp_idx <= pend_idx;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("env_valid", int'(env_valid), int'(exp_vld));
      if (exp_vld) begin
        check("env", int'(env), exp_env);
        check("env_idx", int'(env_idx), exp_idx);
      end
    end
  end

  int r_ar[8], r_dr[8], r_sl[8], r_rr[8], r_tl[8];
  bit r_egt[8], r_key[8], r_am[8];

  initial begin
    int prev_env, idx;
    bit mono, hit_zero;
    for (int i = 0; i < 64; i++) begin
      m_lvl[i] = 511;
      m_st[i] = 3;
      m_pk[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_env", int'(env), 511);
    check("reset_env_valid", int'(env_valid), 0);
    check("reset_env_idx", int'(env_idx), 0);
    chk_en = 1;

    // Slot 0 idle after reset reads back silent.
    strobe(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("first_env", int'(env), 511);
    check("first_valid", int'(env_valid), 1);
    check("first_idx", int'(env_idx), 0);

    // Instant attack, then hold at zero with dr=0.
    strobe(3, 1, 15, 0, 4, 0, 1, 0, 0, 1);
    check("ar15_env", int'(env), 0);
    for (int n = 0; n < 100; n++) strobe(3, 1, 15, 0, 4, 0, 1, 0, 0, 1);
    check("ar15_hold", int'(env), 0);

    // Decay +2/frame into sustain at 0x040, then egt hold.
    for (int n = 0; n < 10; n++) strobe(3, 1, 15, 13, 4, 0, 1, 0, 0, 1);
    check("decay_10", int'(env), 20);
    for (int n = 0; n < 27; n++) strobe(3, 1, 15, 13, 4, 0, 1, 0, 0, 1);
    check("sustain_hold", int'(env), 64);

    // Key-off edge skips the step, then +8/frame.
    strobe(3, 0, 15, 13, 4, 15, 1, 0, 0, 1);
    check("keyoff_edge", int'(env), 64);
    for (int n = 0; n < 48; n++) strobe(3, 0, 15, 13, 4, 15, 1, 0, 0, 1);
    check("release_1c0", int'(env), 448);
    strobe(3, 0, 15, 13, 4, 0, 1, 63, 0, 1);
    check("tl_saturate", int'(env), 511);
    strobe(40, 1, 15, 15, 0, 15, 0, 0, 0, 1);
    check("oob_valid", int'(env_valid), 0);
    strobe(3, 0, 15, 13, 4, 0, 1, 0, 0, 1);
    check("oob_no_write", int'(env), 448);
    for (int n = 0; n < 10; n++) strobe(3, 0, 15, 13, 4, 15, 1, 0, 0, 1);
    check("release_sat", int'(env), 511);

    // ar=12 attack from 0x1FF: monotonic descent to zero.
    strobe(3, 1, 12, 0, 15, 0, 1, 0, 0, 1);
    prev_env = int'(env);
    mono = 1;
    hit_zero = 0;
    for (int n = 0; n < 200 && !hit_zero; n++) begin
      strobe(3, 1, 12, 0, 15, 0, 1, 0, 0, 1);
      if (int'(env) > prev_env) mono = 0;
      prev_env = int'(env);
      if (env == 9'd0) hit_zero = 1;
    end
    check("attack_monotonic", int'(mono), 1);
    check("attack_reaches_zero", int'(hit_zero), 1);

`ifdef FM_EG_TREMOLO_EN
    strobe(10, 1, 15, 0, 15, 0, 1, 0, 1, 0);
    strobe(11, 1, 15, 0, 15, 0, 1, 0, 0, 0);
    for (int n = 0; n < 3328; n++) begin
      strobe(10, 1, 15, 0, 15, 0, 1, 0, 1, 1);
      strobe(11, 1, 15, 0, 15, 0, 1, 0, 0, 0);
    end
`endif

    // Randomized traffic on slots 0..7 plus stray out-of-range strobes.
    for (int s = 0; s < 8; s++) begin
      r_ar[s] = $urandom_range(15, 6);  r_dr[s] = $urandom_range(15, 0);
      r_sl[s] = $urandom_range(15, 0);  r_rr[s] = $urandom_range(15, 5);
      r_tl[s] = $urandom_range(63, 0);  r_egt[s] = 1'($urandom_range(1, 0));
      r_key[s] = 0;                     r_am[s] = 1'($urandom_range(1, 0));
    end
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(3, 0) != 0) begin
        idx = ($urandom_range(15, 0) == 0) ? $urandom_range(63, 36) : $urandom_range(7, 0);
        if (idx < 8) begin
          if ($urandom_range(11, 0) == 0) r_key[idx] = ~r_key[idx];
          if ($urandom_range(31, 0) == 0) r_ar[idx] = $urandom_range(15, 0);
          strobe(idx, r_key[idx], r_ar[idx], r_dr[idx], r_sl[idx], r_rr[idx],
                 r_egt[idx], r_tl[idx], r_am[idx], $urandom_range(2, 0) == 0);
        end else begin
          strobe(idx, 1, 15, 15, 0, 15, 0, 0, 0, $urandom_range(2, 0) == 0);
        end
      end else begin
        idle($urandom_range(2, 0) == 0);
      end
    end

    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
